// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Brief    : Shared architectural constants for the integer register file.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

  // Architectural data width and register-address width.
  localparam int c_xlen   = 32;
  localparam int c_reg_aw = 5;
  localparam int c_nreg   = 1 << c_reg_aw;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Brief    : Per-register pending bits with registered busy flags for the
//             two read ports. An issue sets a bit and a write clears it. When
//             both hit the same register in one cycle, the set wins.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_qual,
  input  logic [AW-1:0] addr_write,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_addr,
  input  logic          rd_en,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  output logic          busy_a,
  output logic          busy_b
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic            w_hit_a;
  logic            w_hit_b;
  logic            r_busy_a;
  logic            r_busy_b;

  // One-hot set/clear masks. Register 0 is excluded, so its bit can never become pending.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_en && (issue_addr != '0)) w_set[issue_addr] = 1'b1;
    if (wr_qual) w_clr[addr_write] = 1'b1;
  end

  assign w_hit_a = wr_qual && (addr_write == addr_a);
  assign w_hit_b = wr_qual && (addr_write == addr_b);

  // Pending vector update. The set is OR-ed in after the clear, so it takes priority.
  always_ff @(posedge clk) begin
    if (!reset) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr) | w_set;
  end

  // Busy flags. A same-cycle write resolves the hazard; a same-cycle issue shows up one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy_a <= 1'b0;
      r_busy_b <= 1'b0;
    end else if (rd_en) begin
      r_busy_a <= r_pending[addr_a] && !w_hit_a;
      r_busy_b <= r_pending[addr_b] && !w_hit_b;
    end
  end

  assign busy_a = r_busy_a;
  assign busy_b = r_busy_b;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Brief    : Two-read / one-write register file. Reads are registered, with
//             write-to-read bypass. Register 0 is hard-wired to zero, and a
//             scoreboard tracks which registers are pending.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_sb
  import riscv_pkg::*;
#(
  parameter int XLEN = c_xlen,
  parameter int NREG = c_nreg,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reg_write,
  input  logic [AW-1:0]   addr_write,
  input  logic [XLEN-1:0] data_write,
  input  logic            rd_en,
  input  logic [AW-1:0]   addr_a,
  input  logic [AW-1:0]   addr_b,
  output logic [XLEN-1:0] data_a,
  output logic [XLEN-1:0] data_b,
  output logic            busy_a,
  output logic            busy_b,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_addr
);

  // Register 0 has no storage; reads of address 0 are forced to zero below.
  logic [XLEN-1:0] r_regs [1:NREG-1];
  logic [XLEN-1:0] r_data_a;
  logic [XLEN-1:0] r_data_b;
  logic [XLEN-1:0] w_rd_a;
  logic [XLEN-1:0] w_rd_b;
  logic            w_wr_qual;

  assign w_wr_qual = reg_write && (addr_write != '0);

  // Read-port lookup, with a same-cycle write to the same register bypassed through.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    if (addr_a != '0) w_rd_a = (w_wr_qual && (addr_write == addr_a)) ? data_write : r_regs[addr_a];
    if (addr_b != '0) w_rd_b = (w_wr_qual && (addr_write == addr_b)) ? data_write : r_regs[addr_b];
  end

  // Register storage; reset clears every implemented register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 1; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_qual) begin
      r_regs[addr_write] <= data_write;
    end
  end

  // Registered read data; holds while rd_en is low (stall).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data_a <= '0;
      r_data_b <= '0;
    end else if (rd_en) begin
      r_data_a <= w_rd_a;
      r_data_b <= w_rd_b;
    end
  end

  assign data_a = r_data_a;
  assign data_b = r_data_b;

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wr_qual    (w_wr_qual),
    .addr_write (addr_write),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rd_en      (rd_en),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .busy_a     (busy_a),
    .busy_b     (busy_b)
  );

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Brief    : Self-checking bench for regfile_sb. Directed scenarios are
//             followed by random traffic, all compared against an
//             array-based architectural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            reg_write;
  logic [AW-1:0]   addr_write;
  logic [XLEN-1:0] data_write;
  logic            rd_en;
  logic [AW-1:0]   addr_a;
  logic [AW-1:0]   addr_b;
  logic [XLEN-1:0] data_a;
  logic [XLEN-1:0] data_b;
  logic            busy_a;
  logic            busy_b;
  logic            issue_en;
  logic [AW-1:0]   issue_addr;

  int n_vec = 0;
  int n_bad = 0;

  // Architectural model: register contents, pending set and the visible outputs.
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_pend [NREG];
  logic [XLEN-1:0] m_da, m_db;
  logic            m_ba, m_bb;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .addr_write (addr_write),
    .data_write (data_write),
    .rd_en      (rd_en),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .data_a     (data_a),
    .data_b     (data_b),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
    .issue_en   (issue_en),
    .issue_addr (issue_addr)
  );

  // Value a read of address a sees this cycle, including any bypassed write.
  function automatic logic [XLEN-1:0] m_read(logic [AW-1:0] a);
    if (a == 0) return '0;
    if (reg_write && addr_write == a) return data_write;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(logic [AW-1:0] a);
    return m_pend[a] && !(reg_write && a != 0 && addr_write == a);
  endfunction

  task automatic check(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic rst, logic we, logic [AW-1:0] aw, logic [XLEN-1:0] dw,
                       logic rd, logic [AW-1:0] aa, logic [AW-1:0] ab,
                       logic ie, logic [AW-1:0] ia);
    reset = rst; reg_write = we; addr_write = aw; data_write = dw;
    rd_en = rd; addr_a = aa; addr_b = ab; issue_en = ie; issue_addr = ia;
  endtask

  // One clock edge: advance the model, compare all outputs, then return at the next negedge.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
      m_da = '0; m_db = '0; m_ba = 0; m_bb = 0;
    end else begin
      if (rd_en) begin
        m_da = m_read(addr_a); m_db = m_read(addr_b);
        m_ba = m_busy(addr_a); m_bb = m_busy(addr_b);
      end
      if (reg_write && addr_write != 0) begin
        m_regs[addr_write] = data_write;
        m_pend[addr_write] = 0;
      end
      if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1;
    end
    #1;
    check("data_a", data_a, m_da);
    check("data_b", data_b, m_db);
    check("busy_a", {31'b0, busy_a}, {31'b0, m_ba});
    check("busy_b", {31'b0, busy_b}, {31'b0, m_bb});
    @(negedge clk);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset, with every other input active so that reset priority is exercised.
    drive(0, 1, 4, 32'hFFFF0000, 1, 4, 4, 1, 4);
    tick(); tick();
    check("rst_data_a", data_a, 32'h0);
    check("rst_busy_a", {31'b0, busy_a}, 32'h0);

    // Write x5, then read it back one cycle later.
    drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 1, 5, 0, 0, 0); tick();
    check("x5_read", data_a, 32'hDEADBEEF);

    // Register 0: writes are ignored and it never becomes pending.
    drive(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0); tick();
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0); tick();
    check("x0_data", data_a, 32'h0);
    check("x0_busy", {31'b0, busy_a}, 32'h0);

    // Same-cycle write and read on both ports (bypass).
    drive(1, 1, 7, 32'h12345678, 1, 7, 7, 0, 0); tick();
    check("bypass_a", data_a, 32'h12345678);
    check("bypass_b", data_b, 32'h12345678);

    // Issue x3, see it busy, then write it and see the busy flag clear.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 3); tick();
    drive(1, 0, 0, 0, 1, 3, 0, 0, 0); tick();
    check("x3_busy", {31'b0, busy_a}, 32'h1);
    drive(1, 1, 3, 32'hA5, 1, 3, 0, 0, 0); tick();
    check("x3_clear", {31'b0, busy_a}, 32'h0);
    check("x3_data", data_a, 32'hA5);

    // A stall holds the outputs across a write to the register being read.
    drive(1, 1, 2, 32'h11, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 1, 2, 0, 0, 0); tick();
    check("stall_pre", data_a, 32'h11);
    drive(1, 1, 2, 32'h22, 0, 2, 0, 0, 0); tick();
    check("stall_hold", data_a, 32'h11);
    drive(1, 0, 0, 0, 1, 2, 0, 0, 0); tick();
    check("stall_release", data_a, 32'h22);

    // Issue and write the same register in one cycle: the issue wins.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 9); tick();
    drive(1, 1, 9, 32'h99, 1, 9, 9, 1, 9); tick();
    drive(1, 0, 0, 0, 1, 9, 9, 0, 0); tick();
    check("x9_busy", {31'b0, busy_a}, 32'h1);
    // Reset during a stall discards the held outputs.
    drive(0, 1, 9, 32'h5, 0, 9, 9, 1, 9); tick();
    check("midrst_data", data_a, 32'h0);
    check("midrst_busy", {31'b0, busy_b}, 32'h0);
    drive(1, 0, 0, 0, 1, 9, 2, 0, 0); tick();
    check("post_rst_x2", data_b, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 1) == 1),
            AW'($urandom_range(0, NREG-1)), $urandom,
            ($urandom_range(0, 3) != 0),
            AW'($urandom_range(0, NREG-1)), AW'($urandom_range(0, NREG-1)),
            ($urandom_range(0, 2) == 0), AW'($urandom_range(0, NREG-1)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_regfile_sb
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count; power of two, 2..64.
REQ-003 SHALL have parameter AW, default $clog2(NREG), address width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port reg_write  input  1  write enable.
REQ-007 SHALL have port addr_write  input  AW  write address.
REQ-008 SHALL have port data_write  input  XLEN  write data.
REQ-009 SHALL have port rd_en  input  1  read-port update enable; low holds both read outputs (stall).
REQ-010 SHALL have ports addr_a, addr_b  input  AW  read addresses.
REQ-011 SHALL have ports data_a, data_b  output  XLEN  registered read data.
REQ-012 SHALL have ports busy_a, busy_b  output  1  registered pending flag of read register.
REQ-013 SHALL have port issue_en  input  1  marks issue_addr as pending (producer in flight).
REQ-014 SHALL have port issue_addr  input  AW  destination being issued.

Function
REQ-015 SHALL store data_write into register[addr_write] at the clock edge when reg_write=1 and addr_write!=0.
REQ-016 SHALL treat register 0 as constant zero: writes ignored, reads return 0, never pending.
REQ-017 SHALL have read latency of exactly 1 cycle: with rd_en=1, data_a/data_b at edge N+1 reflect addr_a/addr_b sampled at edge N.
REQ-018 SHALL perform reads and writes in the same cycle (no read/write mutual exclusion).
REQ-019 SHALL forward data_write to data_a/data_b when reg_write=1 and addr_write equals the read address (non-zero) in the same cycle.
REQ-020 SHALL, with rd_en=0, hold data_a, data_b, busy_a, busy_b unchanged while writes and scoreboard updates continue.
REQ-021 SHALL set pending[issue_addr] on issue_en=1 with issue_addr!=0.
REQ-022 SHALL clear pending[addr_write] on a qualifying write (REQ-015).
REQ-023 SHALL keep pending=1 when issue and write hit the same address in the same cycle (set wins).
REQ-024 SHALL load busy_x with pending[addr_x] AND NOT(same-cycle write to addr_x); a same-cycle issue does not affect busy_x until the next cycle.
REQ-025 SHALL keep both read ports independent; addr_a==addr_b returns identical data and busy.

Reset
REQ-026 SHALL, on reset=0 at a clock edge, clear all registers, pending bits, data_a, data_b, busy_a, busy_b to 0.
REQ-027 SHALL give reset priority over reg_write, issue_en and rd_en in the same cycle.
REQ-028 SHALL resume normal operation at the first edge with reset=1; reset mid-stall discards held outputs.

Structure
REQ-029 SHALL take XLEN default and register-address width constants from the shared package riscv_pkg.
REQ-030 SHALL place the pending-bit vector and its set/clear/busy logic in sub-module regfile_scoreboard.
REQ-031 SHALL hold storage as an NREG x XLEN array with register 0 not implemented as storage.

Verification
REQ-032 SHALL verify: reset, write x5=0xDEADBEEF, read addr_a=5 rd_en=1 -> data_a=0xDEADBEEF one cycle later.
REQ-033 SHALL verify: write x0=0xFFFFFFFF, issue_en to x0, read x0 -> data_a=0, busy_a=0.
REQ-034 SHALL verify: same cycle write x7=0x12345678 and read addr_a=addr_b=7 -> data_a=data_b=0x12345678 next cycle (bypass).
REQ-035 SHALL verify: issue x3, next cycle read x3 -> busy_a=1; write x3=0xA5 with read x3 -> busy_a=0, data_a=0xA5.
REQ-036 SHALL verify: data_a=0x11 held, rd_en=0, write x2=0x22 with addr_a=2 -> data_a stays 0x11; rd_en=1 -> 0x22.
REQ-037 SHALL verify: x9 pending, issue and write x9 same cycle -> busy=1 next read; reset=0 mid-stream -> all outputs 0 next edge.
